// File: rtl/soda_pkg.sv
// soda_pkg: coin codes and shared limits for the vending machine front end.
package soda_pkg;
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_5    = 2'b10,
        COIN_10   = 2'b11
    } coin_e;
    localparam int MIN_GAP = 5;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: two-flop synchronizer, counting debouncer and one-cycle rising event.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic event_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic          sync1_q, sync2_q, level_q, event_q;
    logic          level_d, event_d, flip;
    logic [CW-1:0] cnt_q, cnt_d;
    // flip fires on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with the level
    always_comb begin
        flip    = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (sync2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d = level_q ^ flip;
        event_d = flip && !level_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            event_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            event_q <= event_d;
            cnt_q   <= cnt_d;
        end
    end
    assign event_o = event_q;
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces three coin sensors, queues coins and issues
// spaced single-cycle B1/B5/B10 pulses, flagging coins that cannot be stored.
module coin_acceptor
    import soda_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP             = 5,
    parameter int DEPTH           = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c1_raw,
    input  logic                   c5_raw,
    input  logic                   c10_raw,
    output logic                   B1,
    output logic                   B5,
    output logic                   B10,
    output logic [2:0]             reject,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP);

    if (GAP < MIN_GAP) begin : g_gap_chk
        $error("coin_acceptor: GAP must be at least MIN_GAP");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("coin_acceptor: DEPTH must be a power of 2 and at least 2");
    end

    logic [2:0]    ev, win, reject_d, reject_q;
    coin_e         win_code, head;
    coin_e         fifo_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          full, pop, push, b1_q, b5_q, b10_q;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1  (.clk(clk), .reset(reset), .raw_i(c1_raw),  .event_o(ev[0]));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5  (.clk(clk), .reset(reset), .raw_i(c5_raw),  .event_o(ev[1]));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (.clk(clk), .reset(reset), .raw_i(c10_raw), .event_o(ev[2]));

    // lowest denomination wins, mirroring the vending FSM's input priority
    always_comb begin
        win      = ev[0] ? 3'b001 : ev[1] ? 3'b010 : ev[2] ? 3'b100 : 3'b000;
        win_code = ev[0] ? COIN_1 : ev[1] ? COIN_5 : ev[2] ? COIN_10 : COIN_NONE;
        head     = fifo_q[rd_q];
        full     = count_q == (PW+1)'(DEPTH);
        pop      = count_q != '0 && gap_q == '0;
        push     = |ev && (!full || pop);
        reject_d = (ev & ~win) | (push ? 3'b000 : win);
        count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        gap_d    = pop ? GW'(GAP - 1) : (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= win_code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            reject_q <= '0;
            b1_q     <= 1'b0;
            b5_q     <= 1'b0;
            b10_q    <= 1'b0;
        end else begin
            rd_q     <= pop ? rd_q + 1'b1 : rd_q;
            wr_q     <= push ? wr_q + 1'b1 : wr_q;
            count_q  <= count_d;
            gap_q    <= gap_d;
            reject_q <= reject_d;
            b1_q     <= pop && head == COIN_1;
            b5_q     <= pop && head == COIN_5;
            b10_q    <= pop && head == COIN_10;
        end
    end

    assign B1        = b1_q;
    assign B5        = b5_q;
    assign B10       = b10_q;
    assign reject    = reject_q;
    assign occupancy = count_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed and random sensor stimulus checked every cycle against
// a window-rule debounce model with a timestamped coin queue.
module tb_coin_acceptor;
    localparam int D     = 4;
    localparam int GAP   = 5;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic       c1_raw = 1'b0, c5_raw = 1'b0, c10_raw = 1'b0;
    logic       B1, B5, B10;
    logic [2:0] reject;
    logic [2:0] occupancy;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .c1_raw(c1_raw), .c5_raw(c5_raw), .c10_raw(c10_raw),
        .B1(B1), .B5(B5), .B10(B10), .reject(reject), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, last_pop = -100;
    int q[$];
    int hist[3][$];
    bit lvl[3];
    bit ev[3];
    int exp_code = 0, exp_rej = 0;
    int nb1, nb5, nb10, rej_or;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int rawv(int ch);
        return ch == 0 ? int'(c1_raw) : ch == 1 ? int'(c5_raw) : int'(c10_raw);
    endfunction

    task automatic model_reset();
        q.delete();
        last_pop = -100;
        exp_code = 0;
        exp_rej  = 0;
        for (int ch = 0; ch < 3; ch++) begin
            lvl[ch] = 0;
            ev[ch]  = 0;
            hist[ch].delete();
            repeat (D + 2) hist[ch].push_back(0);
        end
    endtask

    // One clock edge: queue/arbitration on the events of the ending cycle, then the debouncers.
    // A level toggles once the last D synchronized samples (raw delayed 2 edges) all disagree with it.
    task automatic model_step();
        int win;
        bit pop, acc, diff;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        win = -1;
        for (int ch = 2; ch >= 0; ch--) if (ev[ch]) win = ch;
        pop      = q.size() > 0 && (cyc - last_pop) >= GAP;
        exp_code = pop ? q[0] : 0;
        acc      = win >= 0 && (q.size() < DEPTH || pop);
        exp_rej  = 0;
        for (int ch = 0; ch < 3; ch++)
            if (ev[ch] && !(ch == win && acc)) exp_rej |= (1 << ch);
        if (pop) begin
            void'(q.pop_front());
            last_pop = cyc;
        end
        if (acc) q.push_back(win + 1);
        for (int ch = 0; ch < 3; ch++) begin
            hist[ch].push_front(rawv(ch));
            void'(hist[ch].pop_back());
            diff = 1;
            for (int k = 2; k <= D + 1; k++) if (hist[ch][k] == int'(lvl[ch])) diff = 0;
            ev[ch] = diff && !lvl[ch];
            if (diff) lvl[ch] = !lvl[ch];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("B1", int'(B1), int'(exp_code == 1));
        chk("B5", int'(B5), int'(exp_code == 2));
        chk("B10", int'(B10), int'(exp_code == 3));
        chk("reject", int'(reject), exp_rej);
        chk("occupancy", int'(occupancy), q.size());
        nb1 += int'(B1);
        nb5 += int'(B5);
        nb10 += int'(B10);
        rej_or |= int'(reject);
    endtask

    task automatic clr_counts();
        nb1 = 0; nb5 = 0; nb10 = 0; rej_or = 0;
    endtask

    function automatic bit pat(int i, int off);
        return i >= off && (i - off) < 32 && ((i - off) % 8) < 4;
    endfunction

    initial begin
        int n, hold[3];
        bit val[3];
        model_reset();
        clr_counts();
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("reset_occ", int'(occupancy), 0);
        chk("reset_outs", int'({B1, B5, B10, reject}), 0);

        // clean 10-cycle c5 pulse
        clr_counts();
        n = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            c5_raw = i < 10;
            tick();
            if (cyc == n + 6) chk("t1_occ_1", int'(occupancy), 1);
            if (cyc == n + 7) begin
                chk("t1_b5_time", int'(B5), 1);
                chk("t1_occ_0", int'(occupancy), 0);
            end
        end
        chk("t1_b5_count", nb5, 1);
        chk("t1_other", nb1 + nb10, 0);

        // c1 bounce then stable
        clr_counts();
        for (int i = 0; i < 30; i++) begin
            c1_raw = i != 1 && i < 11;
            tick();
        end
        chk("t2_b1_count", nb1, 1);
        chk("t2_no_reject", rej_or, 0);

        // c1 and c10 complete together
        clr_counts();
        n = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            c1_raw  = i < 6;
            c10_raw = i < 6;
            tick();
            if (cyc == n + 6) chk("t3_reject", int'(reject), 4);
        end
        chk("t3_b1_count", nb1, 1);
        chk("t3_b10_count", nb10, 0);

        // staggered burst: fills queue, rejects on full, full+pop accepts 10-unit
        n = cyc + 1;
        for (int i = 0; i < 38; i++) begin
            c1_raw  = pat(i, 0);
            c5_raw  = pat(i, 1);
            c10_raw = pat(i, 2);
            tick();
            if (cyc == n + 24) chk("t4_rej_full10", int'(reject), 4);
            if (cyc == n + 31) begin
                chk("t4_rej_full5", int'(reject), 2);
                chk("t4_occ_full", int'(occupancy), 4);
            end
            if (cyc == n + 32) begin
                chk("t4_occ_keep", int'(occupancy), 4);
                chk("t4_no_rej", int'(reject), 0);
                chk("t4_b10", int'(B10), 1);
            end
        end
        chk("t4_occ_3", int'(occupancy), 3);
        chk("t4_b1_inflight", int'(B1), 1);

        // asynchronous reset with queued coins, c5 held high across release
        c5_raw = 1'b1;
        reset  = 1'b1;
        #1;
        chk("t5_async_b", int'({B1, B5, B10}), 0);
        chk("t5_async_rej", int'(reject), 0);
        chk("t5_async_occ", int'(occupancy), 0);
        repeat (2) tick();
        reset = 1'b0;
        clr_counts();
        for (int i = 0; i < 40; i++) begin
            c5_raw = i < 10;
            tick();
        end
        chk("t5_b5_count", nb5, 1);
        chk("t5_b1_b10", nb1 + nb10, 0);

        // random bouncy sensors
        for (int ch = 0; ch < 3; ch++) begin
            hold[ch] = 0;
            val[ch]  = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    val[ch]  = !val[ch];
                    hold[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 10));
                end
                hold[ch]--;
            end
            c1_raw  = val[0];
            c5_raw  = val[1];
            c10_raw = val[2];
            tick();
        end
        c1_raw = 1'b0; c5_raw = 1'b0; c10_raw = 1'b0;
        repeat (40) tick();
        chk("final_occ", int'(occupancy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
